// File: rtl/complex_conj_arbiter_if.sv
// complex_conj_arbiter_if
// Bundles the two requester handshakes, the shared adder_subtractor port and
// the conjugated output stream of complex_conj_arbiter.
//   req0_* / req1_*  : valid/ready requester channels, data = {real, imag}
//   sub_*            : issue port and result return of the shared adder
//   out_*            : conjugated word stream (no backpressure)
//   issue_cnt0/1     : per-requester accepted-word counters
// Modports: slave = arbiter side, master = requester/adder/sink environment.
interface complex_conj_arbiter_if;
    logic        req0_valid;
    logic [63:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [63:0] req1_data;
    logic        req1_ready;
    logic [31:0] sub_a;
    logic [31:0] sub_b;
    logic        sub_op;
    logic        sub_en;
    logic [31:0] sub_result;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_id;
    logic [15:0] issue_cnt0;
    logic [15:0] issue_cnt1;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, sub_result,
        output req0_ready, req1_ready, sub_a, sub_b, sub_op, sub_en,
        output out_valid, out_data, out_id, issue_cnt0, issue_cnt1
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, sub_result,
        input  req0_ready, req1_ready, sub_a, sub_b, sub_op, sub_en,
        input  out_valid, out_data, out_id, issue_cnt0, issue_cnt1
    );
endinterface

// File: rtl/complex_conj_arbiter.sv
// complex_conj_arbiter
// Arbitrates two requesters of complex single-precision words onto a shared
// adder_subtractor that computes 0 - imag, and re-joins each result with the
// real part carried in a LATENCY-deep tag pipeline, giving the conjugate.
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : complex_conj_arbiter_if.slave (requesters, adder port, output,
//          issue counters)
// Parameter LATENCY (1..16): adder depth from sub_en to sub_result.
// Configuration: define CONJ_ROUND_ROBIN_EN for two-state round-robin
// arbitration; otherwise requester 0 has fixed priority and no state register.
module complex_conj_arbiter #(
    parameter int LATENCY = 4
) (
    input logic                  clk,
    input logic                  rst,
    complex_conj_arbiter_if.slave bus
);

    logic               grant0_s;
    logic               grant1_s;
    logic [31:0]        grant_imag_s;
    logic [31:0]        grant_real_s;
    logic [LATENCY-1:0] tag_valid_r;
    logic [LATENCY-1:0] tag_id_r;
    logic [31:0]        tag_real_r [LATENCY];
    logic [15:0]        issue_cnt0_r;
    logic [15:0]        issue_cnt1_r;

`ifdef CONJ_ROUND_ROBIN_EN
    // PRI0/PRI1 name the requester favoured on the next contention.
    typedef enum logic {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } pri_t;

    pri_t pri_r;

    // Grant decode: favoured requester wins contention, else whoever is valid.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (rst) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else if (bus.req0_valid && bus.req1_valid) begin
            if (pri_r == PRI1) begin
                grant1_s = 1'b1;
            end else begin
                grant0_s = 1'b1;
            end
        end else begin
            grant0_s = bus.req0_valid;
            grant1_s = bus.req1_valid;
        end
    end

    // Priority FSM: only a grant to the favoured requester hands priority over.
    always_ff @(posedge clk) begin
        if (rst) begin
            pri_r <= PRI0;
        end else begin
            case (pri_r)
                PRI0: begin
                    if (grant0_s) pri_r <= PRI1;
                    else          pri_r <= PRI0;
                end
                PRI1: begin
                    if (grant1_s) pri_r <= PRI0;
                    else          pri_r <= PRI1;
                end
                default: pri_r <= PRI0;
            endcase
        end
    end
`else
    // Grant decode: requester 0 always wins; requester 1 only when 0 is idle.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (rst) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else begin
            grant0_s = bus.req0_valid;
            grant1_s = bus.req1_valid & ~bus.req0_valid;
        end
    end
`endif

    // Select the granted word's halves; zero when nothing is issued.
    always_comb begin
        grant_imag_s = 32'h0;
        grant_real_s = 32'h0;
        case ({grant1_s, grant0_s})
            2'b01: begin
                grant_imag_s = bus.req0_data[31:0];
                grant_real_s = bus.req0_data[63:32];
            end
            2'b10: begin
                grant_imag_s = bus.req1_data[31:0];
                grant_real_s = bus.req1_data[63:32];
            end
            default: begin
                grant_imag_s = 32'h0;
                grant_real_s = 32'h0;
            end
        endcase
    end

    // Tag pipeline: shifts every cycle, in step with the adder, never stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid_r <= '0;
            tag_id_r    <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_real_r[i] <= 32'h0;
            end
        end else begin
            tag_valid_r[0] <= grant0_s | grant1_s;
            tag_id_r[0]    <= grant1_s;
            tag_real_r[0]  <= grant_real_s;
            for (int i = 1; i < LATENCY; i++) begin
                tag_valid_r[i] <= tag_valid_r[i-1];
                tag_id_r[i]    <= tag_id_r[i-1];
                tag_real_r[i]  <= tag_real_r[i-1];
            end
        end
    end

    // Per-requester accepted-word counters, free-running wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt0_r <= 16'h0;
            issue_cnt1_r <= 16'h0;
        end else begin
            if (grant0_s) issue_cnt0_r <= issue_cnt0_r + 16'd1;
            else          issue_cnt0_r <= issue_cnt0_r;
            if (grant1_s) issue_cnt1_r <= issue_cnt1_r + 16'd1;
            else          issue_cnt1_r <= issue_cnt1_r;
        end
    end

    assign bus.req0_ready = grant0_s;
    assign bus.req1_ready = grant1_s;
    assign bus.sub_a      = 32'h0;
    assign bus.sub_b      = grant_imag_s;
    assign bus.sub_op     = 1'b1;
    assign bus.sub_en     = grant0_s | grant1_s;
    assign bus.out_valid  = tag_valid_r[LATENCY-1];
    assign bus.out_id     = tag_id_r[LATENCY-1];
    assign bus.out_data   = {tag_real_r[LATENCY-1], bus.sub_result};
    assign bus.issue_cnt0 = issue_cnt0_r;
    assign bus.issue_cnt1 = issue_cnt1_r;

endmodule

// File: doc/complex_conj_arbiter.md
COMPLEX_CONJ_ARBITER -- requirements
Module: complex_conj_arbiter

Interface
REQ-001 Parameter LATENCY, default 4: pipeline depth in clk cycles of the shared adder_subtractor, from sub_en asserted to sub_result valid; legal range 1..16.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 offers a complex word.
REQ-005 req0_data  input  64  requester 0 word: [63:32] real, [31:0] imaginary, both IEEE-754 single.
REQ-006 req0_ready  output  1  requester 0 word accepted this cycle.
REQ-007 req1_valid / req1_data / req1_ready  input 1 / input 64 / output 1  requester 1, same meaning as requester 0.
REQ-008 sub_a  output  32  adder operand A; constant 32'h0.
REQ-009 sub_b  output  32  adder operand B; imaginary part of the granted word.
REQ-010 sub_op  output  1  adder mode; constant 1'b1 (subtract).
REQ-011 sub_en  output  1  adder issue strobe.
REQ-012 sub_result  input  32  adder result, valid LATENCY cycles after the matching sub_en.
REQ-013 out_valid  output  1  conjugated word present on out_data.
REQ-014 out_data  output  64  {real, sub_result}.
REQ-015 out_id  output  1  index of the requester that issued the word.
REQ-016 issue_cnt0, issue_cnt1  output  16 each  words accepted per requester since reset.

Function
REQ-017 At most one request SHALL be granted per cycle; grant means readyN=1 in a cycle where reqN_valid=1, and readyN SHALL be combinational from valid and arbiter state.
REQ-018 readyN SHALL never be 1 while reqN_valid=0.
REQ-019 In the grant cycle, sub_en=1 and sub_b = imaginary part of the granted word; with no grant, sub_en=0 and sub_b=32'h0.
REQ-020 A tag pipeline of LATENCY stages SHALL carry {valid, id, real[31:0]} alongside each issue; it advances every cycle, with no stall.
REQ-021 out_valid SHALL equal the tag valid from the final stage; out_data = {tag real, sub_result}; out_id = tag id. Total latency is LATENCY cycles from grant to out_valid.
REQ-022 There is no output backpressure; throughput SHALL be one word per cycle sustained.
REQ-023 The arbiter has two states, PRI0 and PRI1, naming the requester favoured next: in PRI0 a grant to 0 goes to PRI1; in PRI1 a grant to 1 goes to PRI0. A grant to the non-favoured requester (the favoured one idle) SHALL leave the state unchanged. No grant: state unchanged.
REQ-024 When both are valid, the favoured requester SHALL be granted; the other SHALL see ready=0 and must hold its valid and data.
REQ-025 issue_cntN SHALL increment by 1 on each grant to N, wrapping from 16'hFFFF to 16'h0000 without any flag.
REQ-026 Words SHALL leave in grant order; no reordering.

Reset
REQ-027 When rst=1 at a clk edge: every tag-pipeline valid bit = 0, id/real = 0, arbiter state = PRI0, and issue_cnt0 = issue_cnt1 = 0.
REQ-028 While rst=1, req0_ready = req1_ready = 0 and sub_en = 0; out_valid is 0 from the first edge with rst=1.
REQ-029 Reset asserted mid-stream SHALL discard all in-flight words; none SHALL appear on out_valid after rst deasserts.

Configuration
REQ-030 With macro CONJ_ROUND_ROBIN_EN defined, arbitration SHALL follow REQ-023/REQ-024.
REQ-031 Without CONJ_ROUND_ROBIN_EN, requester 0 SHALL always have fixed priority; the state register is omitted, and requester 1 is granted only when req0_valid=0.

Verification (bench models the adder as a LATENCY-deep pipeline computing sub_a - sub_b)
REQ-032 Single word: req0 data 64'h40000000_3F800000, LATENCY=4 -> out_valid exactly 4 cycles after grant, out_data=64'h40000000_BF800000, out_id=0, issue_cnt0=1.
REQ-033 Both requesters valid for 6 cycles, macro defined -> grants alternate 0,1,0,1,0,1; out_id sequence is identical; each counter reads 3.
REQ-034 Same stimulus as REQ-033, macro undefined -> six grants to 0, none to 1 until req0_valid drops; then req1 is granted the next cycle.
REQ-035 rst pulsed for 1 cycle with 3 words in flight -> no out_valid in the following 8 cycles; counters = 0; state = PRI0.
REQ-036 Preload issue_cnt1 = 16'hFFFF by 65535 grants, then one more grant -> issue_cnt1 = 16'h0000; output data is unaffected.
REQ-037 Negative imaginary: 64'h00000000_C0400000 -> out_data=64'h00000000_40400000.
